// File: rtl/priority_grant_fsm.sv
// Qualifies the encoded request from the upstream priority encoder, issues a registered
// one-hot grant, holds it until done or timeout, then enforces a release gap.
module priority_grant_fsm #(
    parameter int unsigned QUAL_CYCLES = 2,
    parameter int unsigned HOLD_MAX    = 16,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] code_i,
    input  logic       done_i,
    output logic [2:0] grant_o,
    output logic       busy_o,
    output logic [1:0] active_code_o,
    output logic       timeout_o,
    output logic [7:0] grant_count_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [3:0] QUAL_LIM  = 4'(QUAL_CYCLES);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] qual_cnt_q, qual_cnt_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic [2:0] grant_q, grant_d;
    logic [1:0] active_code_q, active_code_d;
    logic       timeout_q, timeout_d;
    logic [7:0] grant_count_q, grant_count_d;
    logic [2:0] code_onehot;

    always_comb begin
        case (active_code_q)
            2'd1:    code_onehot = 3'b001;
            2'd2:    code_onehot = 3'b010;
            2'd3:    code_onehot = 3'b100;
            default: code_onehot = 3'b000;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        qual_cnt_d    = qual_cnt_q;
        hold_cnt_d    = hold_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        grant_d       = grant_q;
        active_code_d = active_code_q;
        timeout_d     = 1'b0;
        grant_count_d = grant_count_q;

        case (state_q)
            IDLE: begin
                if (code_i != 2'd0) begin
                    active_code_d = code_i;
                    qual_cnt_d    = 4'd1;
                    state_d       = QUALIFY;
                end
            end
            QUALIFY: begin
                if (code_i == 2'd0) begin
                    active_code_d = 2'd0;
                    qual_cnt_d    = 4'd0;
                    state_d       = IDLE;
                end else if (code_i != active_code_q) begin
                    active_code_d = code_i;
                    qual_cnt_d    = 4'd1;
                end else if (qual_cnt_q >= QUAL_LIM) begin
                    // Grant lands QUAL_CYCLES edges after QUALIFY entry, even for QUAL_CYCLES = 1
                    grant_d       = code_onehot;
                    hold_cnt_d    = 8'd0;
                    qual_cnt_d    = 4'd0;
                    grant_count_d = grant_count_q + 8'd1;
                    state_d       = GRANT;
                end else begin
                    qual_cnt_d = qual_cnt_q + 4'd1;
                end
            end
            GRANT: begin
                if (done_i || (hold_cnt_q == HOLD_LAST)) begin
                    // done has priority, so timeout only fires when done is absent
                    timeout_d  = !done_i;
                    grant_d    = 3'b000;
                    hold_cnt_d = 8'd0;
                    gap_cnt_d  = 4'd0;
                    state_d    = RELEASE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            RELEASE: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d     = 4'd0;
                    active_code_d = 2'd0;
                    state_d       = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d       = IDLE;
                grant_d       = 3'b000;
                active_code_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            qual_cnt_q    <= 4'd0;
            hold_cnt_q    <= 8'd0;
            gap_cnt_q     <= 4'd0;
            grant_q       <= 3'b000;
            active_code_q <= 2'd0;
            timeout_q     <= 1'b0;
            grant_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            qual_cnt_q    <= qual_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            grant_q       <= grant_d;
            active_code_q <= active_code_d;
            timeout_q     <= timeout_d;
            grant_count_q <= grant_count_d;
        end
    end

    assign grant_o       = grant_q;
    assign busy_o        = (state_q != IDLE);
    assign active_code_o = active_code_q;
    assign timeout_o     = timeout_q;
    assign grant_count_o = grant_count_q;

endmodule

// File: tb/tb_priority_grant_fsm.sv
// Directed self-checking bench for priority_grant_fsm with default parameters
// (QUAL_CYCLES = 2, HOLD_MAX = 16, GAP_CYCLES = 1).
module tb_priority_grant_fsm;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [1:0] code_i = 2'd0;
    logic       done_i = 1'b0;
    logic [2:0] grant_o;
    logic       busy_o;
    logic [1:0] active_code_o;
    logic       timeout_o;
    logic [7:0] grant_count_o;

    int vectors     = 0;
    int miscompares = 0;

    priority_grant_fsm dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .code_i        (code_i),
        .done_i        (done_i),
        .grant_o       (grant_o),
        .busy_o        (busy_o),
        .active_code_o (active_code_o),
        .timeout_o     (timeout_o),
        .grant_count_o (grant_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] code, input logic done);
        code_i = code;
        done_i = done;
    endtask

    task automatic nextEdge();
        @(posedge clk_i);
        #1;
    endtask

    task automatic doReset();
        rst_i = 1'b1;
        applyStimulus(2'd0, 1'b0);
        repeat (2) nextEdge();
        rst_i = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_grant"}, 32'(grant_o), 32'h0);
        checkOutput({tag, "_busy"}, 32'(busy_o), 32'h0);
        checkOutput({tag, "_active"}, 32'(active_code_o), 32'h0);
        checkOutput({tag, "_timeout"}, 32'(timeout_o), 32'h0);
        checkOutput({tag, "_count"}, 32'(grant_count_o), 32'h0);
    endtask

    initial begin
        int hi;
        int grants;

        // Reset held for 3 cycles with a request pending
        applyStimulus(2'd2, 1'b0);
        repeat (3) nextEdge();
        checkAllZero("rst");
        rst_i = 1'b0;
        nextEdge();
        checkOutput("rst_q1_active", 32'(active_code_o), 32'h2);
        checkOutput("rst_q1_busy", 32'(busy_o), 32'h1);
        checkOutput("rst_q1_grant", 32'(grant_o), 32'h0);
        nextEdge();
        checkOutput("rst_q2_grant", 32'(grant_o), 32'h0);
        nextEdge();
        checkOutput("rst_grant", 32'(grant_o), 32'h2);
        checkOutput("rst_count", 32'(grant_count_o), 32'h1);

        // Asynchronous reset in the middle of a grant
        #3 rst_i = 1'b1;
        #1;
        checkAllZero("async");
        repeat (3) nextEdge();
        rst_i = 1'b0;
        nextEdge();
        nextEdge();
        checkOutput("requal_pre", 32'(grant_o), 32'h0);
        nextEdge();
        checkOutput("requal_grant", 32'(grant_o), 32'h2);

        // Normal grant ended by done on the 4th grant cycle
        doReset();
        applyStimulus(2'd3, 1'b0);
        repeat (3) nextEdge();
        checkOutput("done_g1", 32'(grant_o), 32'h4);
        for (int i = 2; i <= 4; i++) begin
            nextEdge();
            checkOutput($sformatf("done_g%0d", i), 32'(grant_o), 32'h4);
        end
        applyStimulus(2'd3, 1'b1);
        nextEdge();
        checkOutput("done_rel_grant", 32'(grant_o), 32'h0);
        checkOutput("done_rel_busy", 32'(busy_o), 32'h1);
        checkOutput("done_rel_timeout", 32'(timeout_o), 32'h0);
        checkOutput("done_rel_active", 32'(active_code_o), 32'h3);
        applyStimulus(2'd0, 1'b0);
        nextEdge();
        checkOutput("done_idle_busy", 32'(busy_o), 32'h0);
        checkOutput("done_idle_active", 32'(active_code_o), 32'h0);
        checkOutput("done_count", 32'(grant_count_o), 32'h1);

        // Forced release after HOLD_MAX cycles
        doReset();
        applyStimulus(2'd1, 1'b0);
        repeat (3) nextEdge();
        checkOutput("to_grant", 32'(grant_o), 32'h1);
        hi = 1;
        for (int i = 0; i < 40; i++) begin
            nextEdge();
            if (grant_o == 3'b001) begin
                checkOutput("to_no_early_pulse", 32'(timeout_o), 32'h0);
                hi++;
            end else begin
                break;
            end
        end
        checkOutput("to_len", 32'(hi), 32'd16);
        checkOutput("to_rel_grant", 32'(grant_o), 32'h0);
        checkOutput("to_pulse", 32'(timeout_o), 32'h1);
        applyStimulus(2'd0, 1'b0);
        nextEdge();
        checkOutput("to_pulse_end", 32'(timeout_o), 32'h0);
        checkOutput("to_busy", 32'(busy_o), 32'h0);
        checkOutput("to_count", 32'(grant_count_o), 32'h1);

        // Qualification glitch: 1, 2, 2, 0 never grants
        doReset();
        applyStimulus(2'd1, 1'b0);
        nextEdge();
        checkOutput("gl_a1", 32'(active_code_o), 32'h1);
        applyStimulus(2'd2, 1'b0);
        nextEdge();
        checkOutput("gl_a2", 32'(active_code_o), 32'h2);
        checkOutput("gl_g2", 32'(grant_o), 32'h0);
        nextEdge();
        checkOutput("gl_a3", 32'(active_code_o), 32'h2);
        checkOutput("gl_g3", 32'(grant_o), 32'h0);
        applyStimulus(2'd0, 1'b0);
        nextEdge();
        checkOutput("gl_a4", 32'(active_code_o), 32'h0);
        checkOutput("gl_g4", 32'(grant_o), 32'h0);
        checkOutput("gl_busy", 32'(busy_o), 32'h0);
        checkOutput("gl_count", 32'(grant_count_o), 32'h0);

        // No preemption, and done colliding with the last hold cycle
        doReset();
        applyStimulus(2'd1, 1'b0);
        repeat (3) nextEdge();
        checkOutput("np_grant", 32'(grant_o), 32'h1);
        applyStimulus(2'd3, 1'b0);
        for (int i = 0; i < 15; i++) begin
            nextEdge();
            checkOutput($sformatf("np_hold%0d", i), 32'(grant_o), 32'h1);
        end
        applyStimulus(2'd3, 1'b1);
        nextEdge();
        checkOutput("np_rel_grant", 32'(grant_o), 32'h0);
        checkOutput("np_rel_timeout", 32'(timeout_o), 32'h0);
        checkOutput("np_rel_busy", 32'(busy_o), 32'h1);
        applyStimulus(2'd3, 1'b0);
        nextEdge();
        checkOutput("np_idle_busy", 32'(busy_o), 32'h0);
        nextEdge();
        checkOutput("np_req_active", 32'(active_code_o), 32'h3);
        nextEdge();
        checkOutput("np_req_grant0", 32'(grant_o), 32'h0);
        nextEdge();
        checkOutput("np_next_grant", 32'(grant_o), 32'h4);
        checkOutput("np_count", 32'(grant_count_o), 32'h2);

        // 256 back-to-back grants released by done
        doReset();
        applyStimulus(2'd1, 1'b1);
        grants = 0;
        for (int i = 0; i < 3000; i++) begin
            nextEdge();
            if (grant_o != 3'b000) begin
                grants++;
                checkOutput("wrap_grant", 32'(grant_o), 32'h1);
                checkOutput($sformatf("wrap_cnt%0d", grants), 32'(grant_count_o), 32'(grants % 256));
                if (grants == 256) break;
            end
        end
        checkOutput("wrap_reached", 32'(grants), 32'd256);
        checkOutput("wrap_zero", 32'(grant_count_o), 32'h0);
        applyStimulus(2'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
